// File: rtl/led_pkg.sv
// Shared types and constants for the status-LED blink arbiter.
//   led_state_e : sequencer states (IDLE, ON, OFF, GAP)
//   DEF_*       : default prescaler/phase lengths for a 24 MHz clk, 10 us tick
//   clog2/cbits : width helpers (cbits never returns less than 1)
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } led_state_e;

  localparam int unsigned DEF_PRESCALE_MAX = 239;
  localparam int unsigned DEF_ON_TICKS     = 15000;
  localparam int unsigned DEF_OFF_TICKS    = 35000;
  localparam int unsigned DEF_GAP_TICKS    = 50000;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  // Bits needed to index v entries, at least one.
  function automatic int unsigned cbits(input int unsigned v);
    return (clog2(v) == 0) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/led_blink_arb_tick_gen.sv
// Free-running prescaler producing a one-clock tick every PRESCALE_MAX+1 clocks.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   tick    : high for one clock while the prescaler sits at PRESCALE_MAX
module tick_gen
  import led_pkg::*;
#(
  parameter int unsigned PRESCALE_MAX = DEF_PRESCALE_MAX
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned PW = cbits(PRESCALE_MAX + 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  // Next prescaler value, wrapping at PRESCALE_MAX.
  always_comb begin
    cnt_d = cnt_q + PW'(1);
    if (cnt_q == PW'(PRESCALE_MAX)) cnt_d = '0;
  end

  // tick is registered from the next count so it tracks cnt_q == PRESCALE_MAX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick  <= (cnt_d == PW'(PRESCALE_MAX));
    end
  end

endmodule

// File: rtl/led_blink_arb.sv
// Round-robin arbiter + blink sequencer sharing one active-low status LED.
//   clk, reset_n : system clock, asynchronous active-low reset
//   req[i]       : request level from requester i, held until ack[i]
//   count[4i+:4] : blinks per burst (0 means 1)
//   level[3i+:3] : brightness, LED lit while pwm phase <= level
//   ack[i]       : one-cycle completion pulse to the granted requester
//   busy         : sequencer not idle
//   grant_id     : current / last granted requester
//   led_n        : LED drive, active low
module led_blink_arb
  import led_pkg::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned PRESCALE_MAX = DEF_PRESCALE_MAX,
  parameter int unsigned ON_TICKS     = DEF_ON_TICKS,
  parameter int unsigned OFF_TICKS    = DEF_OFF_TICKS,
  parameter int unsigned GAP_TICKS    = DEF_GAP_TICKS,
  localparam int unsigned GW          = cbits(NREQ)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] count,
  input  logic [3*NREQ-1:0] level,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic [GW-1:0]     grant_id,
  output logic              led_n
);

  localparam int unsigned MAX_OF_ON_OFF = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned MAX_TICKS     = (MAX_OF_ON_OFF > GAP_TICKS) ? MAX_OF_ON_OFF : GAP_TICKS;
  localparam int unsigned TW            = cbits(MAX_TICKS);

  led_state_e      state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      pwm_ph_q;
  logic [3:0]      blinks_q, blinks_d;
  logic [2:0]      level_q, level_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [NREQ-1:0] ack_d;
  logic            tick;

  logic [3:0]      cnt_a [NREQ];
  logic [2:0]      lvl_a [NREQ];

  logic            rr_found;
  logic [GW-1:0]   rr_idx;
  logic [GW-1:0]   cand;

  tick_gen #(
    .PRESCALE_MAX(PRESCALE_MAX)
  ) u_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  // Per-requester views of the packed count/level buses.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign cnt_a[g] = count[4*g +: 4];
    assign lvl_a[g] = level[3*g +: 3];
  end

  // Round robin: first active request after the last grant, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = grant_q;
    cand     = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = GW'((32'(grant_q) + i) % NREQ);
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // Sequencer next state; an aborted burst (req dropped) skips straight to GAP.
  always_comb begin
    state_d  = state_q;
    timer_d  = tick ? timer_q + TW'(1) : timer_q;
    blinks_d = blinks_q;
    level_d  = level_q;
    grant_d  = grant_q;
    ack_d    = '0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (rr_found) begin
          grant_d  = rr_idx;
          blinks_d = (cnt_a[rr_idx] == 4'd0) ? 4'd1 : cnt_a[rr_idx];
          level_d  = lvl_a[rr_idx];
          state_d  = ON;
        end
      end
      ON: begin
        if (!req[grant_q]) begin
          state_d = GAP;
        end else if (tick && timer_q == TW'(ON_TICKS - 1)) begin
          state_d = OFF;
        end
      end
      OFF: begin
        if (!req[grant_q]) begin
          state_d = GAP;
        end else if (tick && timer_q == TW'(OFF_TICKS - 1)) begin
          blinks_d = blinks_q - 4'd1;
          if (blinks_q == 4'd1) begin
            ack_d[grant_q] = 1'b1;
            state_d        = GAP;
          end else begin
            state_d = ON;
          end
        end
      end
      GAP: begin
        if (tick && timer_q == TW'(GAP_TICKS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Phase timer restarts on every state entry.
    if (state_d != state_q) timer_d = '0;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      pwm_ph_q <= '0;
      blinks_q <= '0;
      level_q  <= '0;
      grant_q  <= GW'(NREQ - 1);
      ack      <= '0;
      busy     <= 1'b0;
      led_n    <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      if (tick) pwm_ph_q <= pwm_ph_q + 3'd1;
      blinks_q <= blinks_d;
      level_q  <= level_d;
      grant_q  <= grant_d;
      ack      <= ack_d;
      busy     <= (state_d != IDLE);
      led_n    <= ~((state_q == ON) && (pwm_ph_q <= level_q));
    end
  end

  assign grant_id = grant_q;

endmodule

// File: tb/tb_led_blink_arb.sv
// Directed self-checking bench for led_blink_arb (NREQ=4, tick every 4 clocks).
module tb_led_blink_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned PM   = 3;
  localparam int unsigned ONT  = 2;
  localparam int unsigned OFFT = 3;
  localparam int unsigned GAPT = 2;
  localparam int unsigned TP   = PM + 1;
  localparam int unsigned BP   = TP * (ONT + OFFT);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] count;
  logic [3*NREQ-1:0] level;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic [1:0]        grant_id;
  logic              led_n;

  int unsigned cyc;
  int          vecs = 0;
  int          errs = 0;

  led_blink_arb #(
    .NREQ(NREQ), .PRESCALE_MAX(PM), .ON_TICKS(ONT), .OFF_TICKS(OFFT), .GAP_TICKS(GAPT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .count(count), .level(level),
    .ack(ack), .busy(busy), .grant_id(grant_id), .led_n(led_n)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; edge k with k % TP == 0 is a tick edge.
  always @(posedge clk) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int unsigned next_tick(input int unsigned e);
    return (e / TP + 1) * TP;
  endfunction

  // Expected led_n after edge k for a burst whose ON entry is edge e.
  function automatic logic led_exp(input int unsigned k, input int unsigned e,
                                   input int unsigned eff, input int unsigned lvl);
    int unsigned t1, s, x;
    logic on;
    t1 = next_tick(e);
    on = 1'b0;
    for (int unsigned b = 0; b < eff; b++) begin
      x = t1 + TP * (ONT - 1) + b * BP;
      s = (b == 0) ? e : x - TP * ONT;
      if (k - 1 >= s && k - 1 <= x - 1) on = 1'b1;
    end
    return !(on && (((k - 1) / TP) % 8) <= lvl);
  endfunction

  task automatic wait_idle(output int unsigned at);
    for (int n = 0; n < 300; n++) begin
      if (busy == 1'b0) break;
      @(negedge clk);
    end
    at = cyc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One complete burst with per-cycle LED checks and exact ack/idle timing.
  task automatic run_burst(input int id, input logic [3:0] cnt, input logic [2:0] lvl,
                           input int align);
    int unsigned e, eff, exp_ack, ack_at, idle_at;
    count[4*id +: 4] = cnt;
    level[3*id +: 3] = lvl;
    if (align >= 0) begin
      for (int n = 0; n < 64; n++) begin
        if (cyc % 32 == unsigned'(align)) break;
        @(negedge clk);
      end
    end
    req[id] = 1'b1;
    @(negedge clk);
    e = cyc;
    chk("busy_on", 32'(busy), 32'd1);
    chk("grant", 32'(grant_id), 32'(id));
    eff = (cnt == 4'd0) ? 1 : 32'(cnt);
    exp_ack = next_tick(e) - TP + eff * BP;
    for (int n = 0; n < 200; n++) begin
      chk("led", 32'(led_n), 32'(led_exp(cyc, e, eff, 32'(lvl))));
      if (ack != '0) break;
      @(negedge clk);
    end
    ack_at = cyc;
    chk("ack_val", 32'(ack), 32'd1 << id);
    chk("ack_time", ack_at, exp_ack);
    req[id] = 1'b0;
    @(negedge clk);
    chk("ack_width", 32'(ack), 32'd0);
    wait_idle(idle_at);
    chk("idle_time", idle_at, exp_ack + TP * GAPT);
  endtask

  initial begin
    int unsigned e, target, idle_at;
    int          exp_ids [5];
    logic [NREQ-1:0] ack_seen;

    req   = '0;
    count = '0;
    level = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd3);
    chk("rst_led", 32'(led_n), 32'd1);
    reset_n = 1'b1;

    // Single request: two full-brightness blinks
    run_burst(0, 4'd2, 3'd7, -1);

    // Reset in the middle of an OFF phase
    count[3:0] = 4'd2;
    level[2:0] = 3'd7;
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    e = cyc;
    chk("mid_grant", 32'(grant_id), 32'd0);
    target = next_tick(e) + TP * (ONT - 1) + 2;
    ack_seen = '0;
    for (int n = 0; n < 100; n++) begin
      if (cyc >= target) break;
      ack_seen |= ack;
      @(negedge clk);
    end
    chk("mid_noack", 32'(ack_seen), 32'd0);
    reset_n = 1'b0;
    req = '0;
    #1;
    chk("arst_led", 32'(led_n), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ack", 32'(ack), 32'd0);
    chk("arst_gid", 32'(grant_id), 32'd3);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_burst(1, 4'd1, 3'd7, -1);

    // Round robin with all requesters pending; 0 re-requests after its ack
    do_reset();
    count = {4{4'd1}};
    level = {4{3'd7}};
    exp_ids = '{0, 1, 2, 3, 0};
    req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (ack != '0) break;
      end
      chk("rr_ack", 32'(ack), 32'd1 << exp_ids[b]);
      chk("rr_gid", 32'(grant_id), 32'(exp_ids[b]));
      req[exp_ids[b]] = 1'b0;
      @(negedge clk);
      chk("rr_ack_width", 32'(ack), 32'd0);
      if (b == 0) req[0] = 1'b1;
    end
    wait_idle(idle_at);
    chk("rr_idle", 32'(busy), 32'd0);

    // Count 0 plays a single blink
    run_burst(2, 4'd0, 3'd7, -1);

    // Brightness: level 0 lights only at pwm phase 0, level 3 at phases 0..3
    run_burst(3, 4'd1, 3'd0, 28);
    run_burst(3, 4'd1, 3'd3, 12);

    // Abort: requester 1 drops req during ON
    count[7:4] = 4'd2;
    level[5:3] = 3'd7;
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    e = cyc;
    chk("ab_grant", 32'(grant_id), 32'd1);
    ack_seen = ack;
    @(negedge clk);
    ack_seen |= ack;
    req[1] = 1'b0;
    @(negedge clk);
    ack_seen |= ack;
    chk("ab_led_still", 32'(led_n), 32'd0);
    @(negedge clk);
    ack_seen |= ack;
    chk("ab_led_off", 32'(led_n), 32'd1);
    chk("ab_busy", 32'(busy), 32'd1);
    for (int n = 0; n < 100; n++) begin
      if (busy == 1'b0) break;
      @(negedge clk);
      ack_seen |= ack;
    end
    chk("ab_idle_time", cyc, next_tick(e + 3) + TP * (GAPT - 1));
    chk("ab_noack", 32'(ack_seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
